// File: rtl/gcm_ghash_tag_pkg.sv
// gcm_pkg: shared types and constants for the GHASH / tag stage.
//   gcm_block_t   : 128-bit block, bit 0 is the GCM leftmost bit
//   GCM_R         : GHASH reduction constant (0xE1 || 0^120)
//   ghash_state_t : states of the tag-generator FSM
package gcm_pkg;

    typedef logic [0:127] gcm_block_t;

    localparam gcm_block_t GCM_R = {8'hE1, 120'h0};

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        MULT,
        LEN,
        FINAL
    } ghash_state_t;

endpackage

// File: rtl/gcm_ghash_tag_if.sv
// gcm_ghash_tag_if: instance-setup, block-stream and tag signals of the
// GHASH / tag stage.
//   master : upstream side (drives i_* signals, observes o_* signals)
//   slave  : the gcm_ghash_tag block
//   i_new_instance  1-cycle start pulse, latches i_h / i_encrypted_j0 / i_instance_size
//   i_h             hash subkey H
//   i_encrypted_j0  E(K,J0)
//   i_instance_size {aad_len_bits[0:63], pt_len_bits[0:63]}
//   i_block_valid   i_block carries an AAD or ciphertext block
//   o_block_ready   block accepted on edges where valid && ready
//   o_tag           GCM tag, held until overwritten
//   o_tag_valid     1-cycle pulse when o_tag is updated
interface gcm_ghash_tag_if;
    import gcm_pkg::*;

    logic       i_new_instance;
    gcm_block_t i_h;
    gcm_block_t i_encrypted_j0;
    gcm_block_t i_instance_size;
    logic       i_block_valid;
    gcm_block_t i_block;
    logic       o_block_ready;
    gcm_block_t o_tag;
    logic       o_tag_valid;

    modport master (
        output i_new_instance, i_h, i_encrypted_j0, i_instance_size,
               i_block_valid, i_block,
        input  o_block_ready, o_tag, o_tag_valid
    );

    modport slave (
        input  i_new_instance, i_h, i_encrypted_j0, i_instance_size,
               i_block_valid, i_block,
        output o_block_ready, o_tag, o_tag_valid
    );

endinterface

// File: rtl/gcm_ghash_tag_mult.sv
// gcm_gf128_mult_serial: digit-serial GF(2^128) multiplier, Z = X * H,
// GCM reflected bit order. DIGIT_BITS bits of H are folded per cycle,
// bit 0 first, giving a fixed latency of M = 128/DIGIT_BITS cycles.
//   clk, rst : clock, asynchronous active-high reset
//   i_start  : load i_x and restart (also aborts a multiply in progress)
//   i_x      : multiplicand, sampled on the i_start edge
//   i_h      : multiplier; read digit by digit, must be stable while busy
//   o_z      : product, valid in the cycle o_done is high
//   o_done   : high in the last step cycle; the product is final at that edge
module gcm_gf128_mult_serial
    import gcm_pkg::*;
#(
    parameter int unsigned DIGIT_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  gcm_block_t i_x,
    input  gcm_block_t i_h,
    output gcm_block_t o_z,
    output logic       o_done
);
    localparam int unsigned M  = 128 / DIGIT_BITS;
    localparam int unsigned CW = $clog2(M + 1);

    logic          busy;
    logic [CW-1:0] cnt;
    gcm_block_t    v_q, z_q, v_n, z_n;
    logic [6:0]    bit_idx;

    // One digit step: for each H bit, conditionally accumulate V, then V = V*x mod P.
    always_comb begin
        v_n     = v_q;
        z_n     = z_q;
        bit_idx = '0;
        for (int unsigned j = 0; j < DIGIT_BITS; j++) begin
            bit_idx = 7'((int'(cnt) * DIGIT_BITS) + j);
            if (i_h[bit_idx]) begin
                z_n = z_n ^ v_n;
            end
            v_n = v_n[127] ? ((v_n >> 1) ^ GCM_R) : (v_n >> 1);
        end
    end

    assign o_done = busy && (cnt == CW'(M - 1));
    assign o_z    = z_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            v_q  <= '0;
            z_q  <= '0;
        end else if (i_start) begin
            busy <= 1'b1;
            cnt  <= '0;
            v_q  <= i_x;
            z_q  <= '0;
        end else if (busy) begin
            v_q <= v_n;
            z_q <= z_n;
            if (o_done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcm_ghash_tag.sv
// gcm_ghash_tag: GHASH accumulator and GCM tag generator.
// Per instance it absorbs zero-padded AAD blocks then ciphertext blocks,
// appends the {aad_len, pt_len} block and emits T = E(K,J0) ^ GHASH_H.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : gcm_ghash_tag_if.slave (setup, block stream, tag)
//   DIGIT_BITS : H bits per multiplier cycle, must divide 128
module gcm_ghash_tag
    import gcm_pkg::*;
#(
    parameter int unsigned DIGIT_BITS = 8
) (
    input  logic           clk,
    input  logic           rst,
    gcm_ghash_tag_if.slave bus
);
    localparam gcm_block_t ONES = '1;

    ghash_state_t state;
    gcm_block_t   h_q, ej0_q, s_q;
    logic [63:0]  aad_len_q, pt_len_q;
    logic [56:0]  na_q, nc_q;

    logic [63:0]  aad_len_in, pt_len_in;
    logic [56:0]  na_in, nc_in;
    logic         in_aad, last_blk, blocks_left;
    logic [6:0]   tail_bits;
    gcm_block_t   keep_mask;
    logic         mult_start, mult_done;
    gcm_block_t   mult_x, mult_z;

    assign aad_len_in = bus.i_instance_size[0:63];
    assign pt_len_in  = bus.i_instance_size[64:127];
    assign na_in      = aad_len_in[63:7] + 57'(aad_len_in[6:0] != 7'd0);
    assign nc_in      = pt_len_in[63:7] + 57'(pt_len_in[6:0] != 7'd0);

    // Remaining-block counters double as the AAD/C phase and last-block flags.
    assign blocks_left = (na_q != '0) || (nc_q != '0);
    assign in_aad      = (na_q != '0);
    assign last_blk    = in_aad ? (na_q == 57'd1) : (nc_q == 57'd1);
    assign tail_bits   = in_aad ? aad_len_q[6:0] : pt_len_q[6:0];
    assign keep_mask   = (last_blk && (tail_bits != 7'd0)) ? ~(ONES >> tail_bits) : ONES;

    // Multiplier is (re)started on every new instance, every accepted block,
    // and when the last data product completes (length block follows at once).
    always_comb begin
        mult_start = 1'b0;
        mult_x     = '0;
        if (bus.i_new_instance) begin
            mult_start = 1'b1;
            mult_x     = bus.i_instance_size;
        end else if ((state == ACCEPT) && bus.i_block_valid) begin
            mult_start = 1'b1;
            mult_x     = s_q ^ (bus.i_block & keep_mask);
        end else if ((state == MULT) && mult_done && !blocks_left) begin
            mult_start = 1'b1;
            mult_x     = mult_z ^ {aad_len_q, pt_len_q};
        end
    end

    gcm_gf128_mult_serial #(
        .DIGIT_BITS (DIGIT_BITS)
    ) u_mult (
        .clk     (clk),
        .rst     (rst),
        .i_start (mult_start),
        .i_x     (mult_x),
        .i_h     (h_q),
        .o_z     (mult_z),
        .o_done  (mult_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            h_q               <= '0;
            ej0_q             <= '0;
            s_q               <= '0;
            aad_len_q         <= '0;
            pt_len_q          <= '0;
            na_q              <= '0;
            nc_q              <= '0;
            bus.o_tag         <= '0;
            bus.o_tag_valid   <= 1'b0;
            bus.o_block_ready <= 1'b0;
        end else begin
            bus.o_tag_valid <= 1'b0;
            if (bus.i_new_instance) begin
                h_q       <= bus.i_h;
                ej0_q     <= bus.i_encrypted_j0;
                aad_len_q <= aad_len_in;
                pt_len_q  <= pt_len_in;
                na_q      <= na_in;
                nc_q      <= nc_in;
                s_q       <= '0;
                if ((na_in != '0) || (nc_in != '0)) begin
                    state             <= ACCEPT;
                    bus.o_block_ready <= 1'b1;
                end else begin
                    state             <= LEN;
                    bus.o_block_ready <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        bus.o_block_ready <= 1'b0;
                    end
                    ACCEPT: begin
                        if (bus.i_block_valid) begin
                            state             <= MULT;
                            bus.o_block_ready <= 1'b0;
                            if (in_aad) begin
                                na_q <= na_q - 57'd1;
                            end else begin
                                nc_q <= nc_q - 57'd1;
                            end
                        end
                    end
                    MULT: begin
                        if (mult_done) begin
                            s_q <= mult_z;
                            if (blocks_left) begin
                                state             <= ACCEPT;
                                bus.o_block_ready <= 1'b1;
                            end else begin
                                state <= LEN;
                            end
                        end
                    end
                    LEN: begin
                        if (mult_done) begin
                            s_q   <= mult_z;
                            state <= FINAL;
                        end
                    end
                    FINAL: begin
                        bus.o_tag       <= ej0_q ^ s_q;
                        bus.o_tag_valid <= 1'b1;
                        state           <= IDLE;
                    end
                    default: begin
                        state             <= IDLE;
                        bus.o_block_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gcm_ghash_tag.sv
// tb_gcm_ghash_tag: scoreboard bench for gcm_ghash_tag. Three instances
// (DIGIT_BITS 8, 1, 32) share clk/rst; each has its own interface, driver
// variables and expected-tag queue. The reference model computes GHASH by
// polynomial multiplication followed by reduction modulo x^128+x^7+x^2+x+1.
module tb_gcm_ghash_tag;
    import gcm_pkg::*;

    localparam gcm_block_t TC_H    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam gcm_block_t TC_EJ0  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam gcm_block_t TC2_C   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam gcm_block_t TC2_TAG = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam gcm_block_t TCP_C   = 128'h0388dace60b6a392ffffffffffffffff;

    typedef struct packed {
        gcm_block_t  tag;
        logic [31:0] edge_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic        new_inst [3];
    gcm_block_t  h_v      [3];
    gcm_block_t  ej_v     [3];
    gcm_block_t  sz_v     [3];
    gcm_block_t  blk_v    [3];
    logic        bv       [3];
    logic        rdy      [3];
    logic        tv       [3];
    gcm_block_t  tag_o    [3];

    exp_t        exp_q [3][$];
    gcm_block_t  stim_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned db_of(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 1 : 32);
    endfunction

    function automatic int unsigned m_of(input int k);
        return 128 / db_of(k);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        gcm_ghash_tag_if bus ();
        assign bus.i_new_instance  = new_inst[g];
        assign bus.i_h             = h_v[g];
        assign bus.i_encrypted_j0  = ej_v[g];
        assign bus.i_instance_size = sz_v[g];
        assign bus.i_block_valid   = bv[g];
        assign bus.i_block         = blk_v[g];
        assign rdy[g]              = bus.o_block_ready;
        assign tv[g]               = bus.o_tag_valid;
        assign tag_o[g]            = bus.o_tag;

        gcm_ghash_tag #(
            .DIGIT_BITS (db_of(g))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    // ---------------- reference model ----------------
    function automatic gcm_block_t gf_mul(input gcm_block_t a, input gcm_block_t b);
        logic [254:0] p;
        gcm_block_t   r;
        p = '0;
        for (int i = 0; i < 128; i++)
            for (int j = 0; j < 128; j++)
                p[i+j] = p[i+j] ^ (a[i] & b[j]);
        for (int d = 254; d >= 128; d--) begin
            if (p[d]) begin
                p[d]     = 1'b0;
                p[d-128] = ~p[d-128];
                p[d-127] = ~p[d-127];
                p[d-126] = ~p[d-126];
                p[d-121] = ~p[d-121];
            end
        end
        for (int i = 0; i < 128; i++) r[i] = p[i];
        return r;
    endfunction

    function automatic gcm_block_t mask_blk(input gcm_block_t b, input int unsigned idx,
                                            input logic [63:0] len);
        gcm_block_t r;
        r = b;
        for (int unsigned i = 0; i < 128; i++)
            if ((64'(idx) * 64'd128 + 64'(i)) >= len) r[i] = 1'b0;
        return r;
    endfunction

    function automatic gcm_block_t model_tag(input gcm_block_t h, input gcm_block_t ej,
                                             input logic [63:0] alen, input logic [63:0] plen);
        int unsigned na, nc;
        gcm_block_t  s;
        na = 32'((alen + 64'd127) / 64'd128);
        nc = 32'((plen + 64'd127) / 64'd128);
        s  = '0;
        for (int unsigned j = 0; j < na; j++) s = gf_mul(s ^ mask_blk(stim_q[j], j, alen), h);
        for (int unsigned j = 0; j < nc; j++) s = gf_mul(s ^ mask_blk(stim_q[na+j], j, plen), h);
        s = gf_mul(s ^ {alen, plen}, h);
        return ej ^ s;
    endfunction

    function automatic gcm_block_t rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input int k, input gcm_block_t got, input gcm_block_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s inst%0d got %h want %h", name, k, got, want);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (tv[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_tag inst%0d got %h want no tag", k, tag_o[k]);
                    end else begin
                        e = exp_q[k].pop_front();
                        check("tag_value", k, tag_o[k], e.tag);
                        check("tag_cycle", k, 128'(cyc), 128'(e.edge_n));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_instance(input int k, input gcm_block_t h, input gcm_block_t ej,
                                  input logic [63:0] alen, input logic [63:0] plen,
                                  input bit vos, output int unsigned t);
        @(negedge clk);
        new_inst[k] = 1'b1;
        h_v[k]      = h;
        ej_v[k]     = ej;
        sz_v[k]     = {alen, plen};
        bv[k]       = vos;
        blk_v[k]    = rand_blk();
        t           = cyc + 1;
        @(negedge clk);
        new_inst[k] = 1'b0;
        bv[k]       = 1'b0;
    endtask

    task automatic feed_blocks(input int k, input bit hold, output int unsigned last_t);
        int unsigned i = 0;
        int unsigned waited = 0;
        last_t = 0;
        while ((i < stim_q.size()) && (waited < 4000)) begin
            bv[k] = hold || ($urandom_range(0, 3) != 0);
            if (bv[k] && rdy[k]) begin
                blk_v[k] = stim_q[i];
                i++;
                last_t = cyc + 1;
            end else begin
                blk_v[k] = rand_blk();
            end
            @(negedge clk);
            waited++;
        end
        if (i < stim_q.size()) begin
            vectors++;
            miscompares++;
            $display("FAIL feed_timeout inst%0d got %0d blocks accepted want %0d", k, i, stim_q.size());
        end
        if (!hold) bv[k] = 1'b0;
    endtask

    task automatic wait_drain(input int k, input int unsigned idle);
        int unsigned w = 0;
        while ((exp_q[k].size() != 0) && (w < 3000)) begin
            @(negedge clk);
            w++;
        end
        if (exp_q[k].size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL tag_timeout inst%0d got no tag want %0d pending", k, exp_q[k].size());
            exp_q[k].delete();
        end
        repeat (idle) @(negedge clk);
    endtask

    task automatic run_instance(input int k, input gcm_block_t h, input gcm_block_t ej,
                                input logic [63:0] alen, input logic [63:0] plen,
                                input bit hold, input bit vos, input gcm_block_t want);
        int unsigned t, lt, m;
        exp_t        e;
        logic        bad;
        m = m_of(k);
        start_instance(k, h, ej, alen, plen, vos, t);
        check("ready_after_start", k, 128'(rdy[k]), 128'(stim_q.size() != 0));
        e.tag = want;
        if (stim_q.size() == 0) begin
            e.edge_n = 32'(t + m + 1);
            exp_q[k].push_back(e);
        end else begin
            feed_blocks(k, hold, lt);
            e.edge_n = 32'(lt + 2 * m + 1);
            exp_q[k].push_back(e);
            if (hold) begin
                bad = 1'b0;
                repeat (2 * m) begin
                    blk_v[k] = rand_blk();
                    if (rdy[k] !== 1'b0) bad = 1'b1;
                    @(negedge clk);
                end
                bv[k] = 1'b0;
                check("ready_low_after_last", k, 128'(bad), 128'(0));
            end
        end
        wait_drain(k, 3);
    endtask

    task automatic fill_random(input logic [63:0] alen, input logic [63:0] plen);
        int unsigned n;
        n = 32'((alen + 64'd127) / 64'd128) + 32'((plen + 64'd127) / 64'd128);
        stim_q.delete();
        repeat (n) stim_q.push_back(rand_blk());
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int unsigned t, lt;
        logic [63:0] alen, plen;
        gcm_block_t  hr, er;

        for (int k = 0; k < 3; k++) begin
            new_inst[k] = 1'b0;
            h_v[k]      = '0;
            ej_v[k]     = '0;
            sz_v[k]     = '0;
            bv[k]       = 1'b0;
            blk_v[k]    = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_tag", 0, tag_o[0], '0);
        check("reset_tag_valid", 0, 128'(tv[0]), 128'(0));
        check("reset_ready", 0, 128'(rdy[0]), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // NIST TC1: no AAD, no plaintext
        stim_q.delete();
        run_instance(0, TC_H, TC_EJ0, 64'd0, 64'd0, 1'b0, 1'b0, TC_EJ0);

        // NIST TC2: one ciphertext block
        stim_q.delete();
        stim_q.push_back(TC2_C);
        run_instance(0, TC_H, TC_EJ0, 64'd0, 64'd128, 1'b0, 1'b0, TC2_TAG);

        // Partial final block: tail bits must be ignored
        stim_q.delete();
        stim_q.push_back(TCP_C);
        run_instance(0, TC_H, TC_EJ0, 64'd0, 64'd64, 1'b0, 1'b0,
                     model_tag(TC_H, TC_EJ0, 64'd0, 64'd64));

        // Random instances, some with valid held high throughout
        for (int n = 0; n < 12; n++) begin
            alen = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 3) * 128)
                                               : 64'($urandom_range(0, 520));
            plen = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 3) * 128)
                                               : 64'($urandom_range(0, 520));
            hr = rand_blk();
            er = rand_blk();
            fill_random(alen, plen);
            run_instance(0, hr, er, alen, plen, ($urandom_range(0, 2) == 0), 1'b0,
                         model_tag(hr, er, alen, plen));
        end

        // New instance while ready, with a block offered on the same edge
        alen = 64'd200;
        plen = 64'd100;
        fill_random(alen, plen);
        start_instance(0, rand_blk(), rand_blk(), alen, plen, 1'b0, t);
        @(negedge clk);
        hr = rand_blk();
        er = rand_blk();
        run_instance(0, hr, er, alen, plen, 1'b1, 1'b1, model_tag(hr, er, alen, plen));

        // Abort TC2 during MULT with a TC1 restart: exactly one tag
        stim_q.delete();
        stim_q.push_back(TC2_C);
        start_instance(0, TC_H, TC_EJ0, 64'd0, 64'd128, 1'b0, t);
        feed_blocks(0, 1'b0, lt);
        @(negedge clk);
        stim_q.delete();
        run_instance(0, TC_H, TC_EJ0, 64'd0, 64'd0, 1'b0, 1'b0, TC_EJ0);
        repeat (300) @(negedge clk);

        // DIGIT_BITS sweep: same TC2 tag, latency scaled by M
        for (int k = 1; k < 3; k++) begin
            stim_q.delete();
            stim_q.push_back(TC2_C);
            run_instance(k, TC_H, TC_EJ0, 64'd0, 64'd128, 1'b0, 1'b0, TC2_TAG);
        end

        // Asynchronous reset in the middle of the length multiply
        stim_q.delete();
        start_instance(0, TC_H, TC2_TAG, 64'd0, 64'd0, 1'b0, t);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_tag", 0, tag_o[0], '0);
        check("rst_mid_tag_valid", 0, 128'(tv[0]), 128'(0));
        check("rst_mid_ready", 0, 128'(rdy[0]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
